dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: PRIO_INIT, default 0, requester index that holds round-robin priority after reset.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mN_req_valid  input  1  requester N (N=0,1) has a command.
REQ-005 mN_req_ready  output  1  requester N command accepted this cycle.
REQ-006 mN_req_we  input  1  1 = store, 0 = load.
REQ-007 mN_req_funct3  input  3  RV32I width code.
REQ-008 mN_req_addr  input  32  byte address.
REQ-009 mN_req_wdata  input  32  store data, right-aligned.
REQ-010 mN_rsp_valid  output  1  one-cycle response pulse to requester N.
REQ-011 mN_rsp_err  output  1  command rejected (misaligned or illegal funct3), qualified by rsp_valid.
REQ-012 mN_rsp_rdata  output  32  load data, qualified by rsp_valid; 0 for stores and errors.
REQ-013 mem_we  output  1  write enable to data_memory.
REQ-014 mem_funct3  output  3  width code to data_memory.
REQ-015 mem_a  output  32  address to data_memory.
REQ-016 mem_wd  output  32  write data to data_memory.
REQ-017 mem_rd  input  32  combinational read data from data_memory.

Function
REQ-018 FSM states IDLE, BUSY, RESP; one transaction in flight; 3 cycles per transaction.
REQ-019 IDLE: if any mN_req_valid, winner's mN_req_ready SHALL be high combinationally that cycle; command latched at edge; next state BUSY.
REQ-020 Arbitration: one valid -> grant it; both valid -> grant priority pointer; after grant pointer = other index.
REQ-021 Loser's req_ready SHALL stay 0; requester holds valid and command stable until ready.
REQ-022 req_ready SHALL be 0 in BUSY and RESP.
REQ-023 BUSY: mem_a/mem_funct3/mem_wd driven from latched command; mem_we = latched we AND command legal AND not rst.
REQ-024 BUSY: for legal loads, mem_rd captured into response register at end of cycle; next state RESP.
REQ-025 RESP: winner's rsp_valid = 1 for exactly one cycle with registered rsp_err/rsp_rdata; next state IDLE.
REQ-026 Legal loads: funct3 000,001,010,100,101; legal stores: 000,001,010; all others -> rsp_err=1.
REQ-027 Alignment: 001/101 require addr[0]=0; 010 require addr[1:0]=00; violation -> rsp_err=1.
REQ-028 Error commands SHALL never assert mem_we and return rsp_rdata = 0.
REQ-029 Outside BUSY: mem_we = 0, mem_a/mem_wd/mem_funct3 = 0.
REQ-030 Non-winning requester's rsp_valid SHALL remain 0.

Reset
REQ-031 While rst high: state IDLE, pointer = PRIO_INIT, all outputs 0, mem_we 0 that same cycle.
REQ-032 rst during BUSY aborts: no memory write, no response issued; latched command discarded.
REQ-033 rst during RESP suppresses the pending response pulse.
REQ-034 First cycle after rst deasserts: IDLE, arbitration fully functional.

Verification
REQ-035 m0 SW addr 0 wdata DEADBEEF -> m0_req_ready cycle 0, mem_we=1 cycle 1, m0_rsp_valid cycle 2 err=0 rdata=0.
REQ-036 m1 LW addr 0 after REQ-035 -> m1_rsp_valid, rdata DEADBEEF, err=0; m0_rsp_valid stays 0.
REQ-037 m0 and m1 both valid from reset, PRIO_INIT=0 -> grant order m0, m1, m0, m1 across four back-to-back transactions.
REQ-038 m0 LW addr 2 -> rsp_err=1, rdata 0, mem_we never asserted; m0 SH addr 1 likewise.
REQ-039 m1 SB addr 1 wdata AA then LBU addr 1 -> rdata 000000AA; LB addr 1 after SB 80 -> FFFFFF80.
REQ-040 rst asserted during BUSY of m0 SW addr 4 wdata 12345678 -> no rsp_valid; subsequent LW addr 4 returns prior memory value.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin front end for a single-port data memory: one command in flight, 3 cycles each.
// Legality (width code, alignment) is checked on the latched command; errored commands never write memory.
module dmem_arbiter #(
    parameter int unsigned PRIO_INIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic        m0_req_we,
    input  logic [2:0]  m0_req_funct3,
    input  logic [31:0] m0_req_addr,
    input  logic [31:0] m0_req_wdata,
    output logic        m0_rsp_valid,
    output logic        m0_rsp_err,
    output logic [31:0] m0_rsp_rdata,
    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic        m1_req_we,
    input  logic [2:0]  m1_req_funct3,
    input  logic [31:0] m1_req_addr,
    input  logic [31:0] m1_req_wdata,
    output logic        m1_rsp_valid,
    output logic        m1_rsp_err,
    output logic [31:0] m1_rsp_rdata,
    output logic        mem_we,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, state_nxt;
    logic        ptr;
    logic        owner;
    logic        cmd_we;
    logic [2:0]  cmd_funct3;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic any_req;
    logic win;
    logic accept;
    logic legal_f3;
    logic aligned;
    logic cmd_ok;
    logic busy_out;
    logic resp_out;

    // Winner index: pointer breaks the tie only when both are requesting.
    assign any_req = m0_req_valid | m1_req_valid;
    assign win     = (m0_req_valid && m1_req_valid) ? ptr : m1_req_valid;
    assign accept  = (state == IDLE) && any_req && !rst;

    assign m0_req_ready = accept && !win;
    assign m1_req_ready = accept && win;

    always_comb begin
        legal_f3 = 1'b0;
        aligned  = 1'b1;
        if (cmd_we) begin
            legal_f3 = (cmd_funct3 == 3'b000) || (cmd_funct3 == 3'b001) || (cmd_funct3 == 3'b010);
        end else begin
            legal_f3 = (cmd_funct3 == 3'b000) || (cmd_funct3 == 3'b001) || (cmd_funct3 == 3'b010) ||
                       (cmd_funct3 == 3'b100) || (cmd_funct3 == 3'b101);
        end
        case (cmd_funct3)
            3'b001, 3'b101: aligned = !cmd_addr[0];
            3'b010:         aligned = (cmd_addr[1:0] == 2'b00);
            default:        aligned = 1'b1;
        endcase
    end

    assign cmd_ok = legal_f3 && aligned;

    // Memory port and response outputs are all forced low while rst is high.
    assign busy_out   = (state == BUSY) && !rst;
    assign mem_we     = busy_out && cmd_we && cmd_ok;
    assign mem_funct3 = busy_out ? cmd_funct3 : 3'b000;
    assign mem_a      = busy_out ? cmd_addr : 32'd0;
    assign mem_wd     = busy_out ? cmd_wdata : 32'd0;

    assign resp_out     = (state == RESP) && !rst;
    assign m0_rsp_valid = resp_out && !owner;
    assign m1_rsp_valid = resp_out && owner;
    assign m0_rsp_err   = m0_rsp_valid && rsp_err_q;
    assign m1_rsp_err   = m1_rsp_valid && rsp_err_q;
    assign m0_rsp_rdata = m0_rsp_valid ? rsp_rdata_q : 32'd0;
    assign m1_rsp_rdata = m1_rsp_valid ? rsp_rdata_q : 32'd0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= (PRIO_INIT != 0);
            owner       <= 1'b0;
            cmd_we      <= 1'b0;
            cmd_funct3  <= 3'b000;
            cmd_addr    <= 32'd0;
            cmd_wdata   <= 32'd0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner      <= win;
                ptr        <= !win;
                cmd_we     <= win ? m1_req_we     : m0_req_we;
                cmd_funct3 <= win ? m1_req_funct3 : m0_req_funct3;
                cmd_addr   <= win ? m1_req_addr   : m0_req_addr;
                cmd_wdata  <= win ? m1_req_wdata  : m0_req_wdata;
            end
            if (state == BUSY) begin
                rsp_err_q   <= !cmd_ok;
                rsp_rdata_q <= (cmd_ok && !cmd_we) ? mem_rd : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array data memory model, directed commands, response scoreboard.
// Expected responses are queued at grant time and popped by an independent monitor.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_req_we;
    logic [2:0]  m0_req_funct3;
    logic [31:0] m0_req_addr, m0_req_wdata;
    logic        m0_rsp_valid, m0_rsp_err;
    logic [31:0] m0_rsp_rdata;
    logic        m1_req_valid, m1_req_ready, m1_req_we;
    logic [2:0]  m1_req_funct3;
    logic [31:0] m1_req_addr, m1_req_wdata;
    logic        m1_rsp_valid, m1_rsp_err;
    logic [31:0] m1_rsp_rdata;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_a, mem_wd, mem_rd;

    dmem_arbiter #(.PRIO_INIT(0)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
        .m0_req_funct3(m0_req_funct3), .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_err(m0_rsp_err), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
        .m1_req_funct3(m1_req_funct3), .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_err(m1_rsp_err), .m1_rsp_rdata(m1_rsp_rdata),
        .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Little-endian byte memory with RV32I load extension, combinational read.
    logic [7:0] mem [0:255];
    logic [7:0] ma;

    always_comb begin
        ma     = mem_a[7:0];
        mem_rd = 32'd0;
        case (mem_funct3)
            3'b000: mem_rd = {{24{mem[ma][7]}}, mem[ma]};
            3'b001: mem_rd = {{16{mem[ma+8'd1][7]}}, mem[ma+8'd1], mem[ma]};
            3'b010: mem_rd = {mem[ma+8'd3], mem[ma+8'd2], mem[ma+8'd1], mem[ma]};
            3'b100: mem_rd = {24'd0, mem[ma]};
            3'b101: mem_rd = {16'd0, mem[ma+8'd1], mem[ma]};
            default: mem_rd = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            case (mem_funct3)
                3'b000: mem[mem_a[7:0]] <= mem_wd[7:0];
                3'b001: begin
                    mem[mem_a[7:0]]       <= mem_wd[7:0];
                    mem[mem_a[7:0]+8'd1]  <= mem_wd[15:8];
                end
                3'b010: begin
                    mem[mem_a[7:0]]       <= mem_wd[7:0];
                    mem[mem_a[7:0]+8'd1]  <= mem_wd[15:8];
                    mem[mem_a[7:0]+8'd2]  <= mem_wd[23:16];
                    mem[mem_a[7:0]+8'd3]  <= mem_wd[31:24];
                end
                default: ;
            endcase
        end
    end

    typedef struct {
        logic        id;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (m0_rsp_valid === 1'b1 || m1_rsp_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_rsp", {m1_rsp_valid, m0_rsp_valid}, 0);
            end else begin
                e = q.pop_front();
                check("rsp_id", {m1_rsp_valid, m0_rsp_valid}, e.id ? 32'd2 : 32'd1);
                check("rsp_err", e.id ? m1_rsp_err : m0_rsp_err, e.err);
                check("rsp_rdata", e.id ? m1_rsp_rdata : m0_rsp_rdata, e.rdata);
            end
        end
    end

    task automatic set_req(input logic id, input logic v, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
        if (id) begin
            m1_req_valid = v; m1_req_we = we; m1_req_funct3 = f3; m1_req_addr = a; m1_req_wdata = d;
        end else begin
            m0_req_valid = v; m0_req_we = we; m0_req_funct3 = f3; m0_req_addr = a; m0_req_wdata = d;
        end
    endtask

    task automatic wait_ready(input logic id);
        int w = 0;
        #1;
        while (!(id ? m1_req_ready : m0_req_ready) && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
    endtask

    task automatic issue(input string name, input logic id, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic exp_err, input logic [31:0] exp_rdata);
        exp_t e;
        @(negedge clk);
        set_req(id, 1'b1, we, f3, a, d);
        wait_ready(id);
        check({name, "_ready"}, id ? m1_req_ready : m0_req_ready, 1);
        check({name, "_loser"}, id ? m0_req_ready : m1_req_ready, 0);
        e.id = id; e.err = exp_err; e.rdata = exp_rdata;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        set_req(id, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        check({name, "_we"}, mem_we, we && !exp_err);
        check({name, "_addr"}, mem_a, a);
        if (we && !exp_err) check({name, "_wd"}, mem_wd, d);
        @(negedge clk);
        check({name, "_rsp_t"}, id ? m1_rsp_valid : m0_rsp_valid, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_req(1'b0, 1'b1, 1'b1, 3'b010, 32'd0, 32'd1);
        set_req(1'b1, 1'b1, 1'b0, 3'b010, 32'd0, 32'd0);
        #1;
        check("rst_ready", {m1_req_ready, m0_req_ready}, 0);
        check("rst_mem", {mem_we, mem_funct3}, 0);
        check("rst_mem_a", mem_a, 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_rsp", {m1_rsp_valid, m0_rsp_valid, m1_rsp_err, m0_rsp_err}, 0);
        check("rst_rdata", m0_rsp_rdata | m1_rsp_rdata, 0);
        rst = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   w;
        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        do_reset();

        // Store then load through the other requester.
        issue("sw0", 1'b0, 1'b1, 3'b010, 32'd0, 32'hDEADBEEF, 1'b0, 32'd0);
        issue("lw1", 1'b1, 1'b0, 3'b010, 32'd0, 32'd0, 1'b0, 32'hDEADBEEF);

        // Both requesting continuously after reset: strict alternation from m0.
        do_reset();
        set_req(1'b0, 1'b1, 1'b0, 3'b010, 32'd0, 32'd0);
        set_req(1'b1, 1'b1, 1'b0, 3'b010, 32'd0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            w = 0;
            #1;
            while (!(m0_req_ready || m1_req_ready) && w < 20) begin
                @(negedge clk);
                #1;
                w++;
            end
            check("rr_grant", {m1_req_ready, m0_req_ready}, k[0] ? 32'd2 : 32'd1);
            e.id = k[0]; e.err = 1'b0; e.rdata = 32'hDEADBEEF;
            q.push_back(e);
            @(posedge clk);
            @(negedge clk);
        end
        set_req(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        @(negedge clk);

        // Misaligned and illegal width codes.
        issue("lw_mis", 1'b0, 1'b0, 3'b010, 32'd2, 32'd0, 1'b1, 32'd0);
        issue("sh_mis", 1'b0, 1'b1, 3'b001, 32'd1, 32'h1234, 1'b1, 32'd0);
        issue("st_f3", 1'b0, 1'b1, 3'b100, 32'd0, 32'hFFFFFFFF, 1'b1, 32'd0);
        issue("ld_f3", 1'b1, 1'b0, 3'b011, 32'd0, 32'd0, 1'b1, 32'd0);
        issue("lw_keep", 1'b0, 1'b0, 3'b010, 32'd0, 32'd0, 1'b0, 32'hDEADBEEF);

        // Byte/half sub-word accesses and extension.
        issue("sb_aa", 1'b1, 1'b1, 3'b000, 32'd1, 32'h000000AA, 1'b0, 32'd0);
        issue("lbu", 1'b1, 1'b0, 3'b100, 32'd1, 32'd0, 1'b0, 32'h000000AA);
        issue("sb_80", 1'b1, 1'b1, 3'b000, 32'd1, 32'h12345680, 1'b0, 32'd0);
        issue("lb", 1'b1, 1'b0, 3'b000, 32'd1, 32'd0, 1'b0, 32'hFFFFFF80);
        issue("lh", 1'b0, 1'b0, 3'b001, 32'd0, 32'd0, 1'b0, 32'hFFFF80EF);
        issue("lhu", 1'b0, 1'b0, 3'b101, 32'd0, 32'd0, 1'b0, 32'h000080EF);
        issue("lw_mix", 1'b0, 1'b0, 3'b010, 32'd0, 32'd0, 1'b0, 32'hDEAD80EF);

        // Reset while the store is in BUSY: no write, no response.
        issue("sw4", 1'b0, 1'b1, 3'b010, 32'd4, 32'h11111111, 1'b0, 32'd0);
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b1, 3'b010, 32'd4, 32'h12345678);
        wait_ready(1'b0);
        check("abort_ready", m0_req_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        check("abort_we", mem_we, 0);
        @(negedge clk);
        rst = 1'b0;
        issue("lw4", 1'b1, 1'b0, 3'b010, 32'd4, 32'd0, 1'b0, 32'h11111111);

        // Reset during RESP swallows the pulse.
        @(negedge clk);
        set_req(1'b1, 1'b1, 1'b0, 3'b010, 32'd4, 32'd0);
        wait_ready(1'b1);
        check("rabort_ready", m1_req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        set_req(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rabort_rsp", {m1_rsp_valid, m0_rsp_valid}, 0);
        @(negedge clk);
        rst = 1'b0;
        issue("post", 1'b1, 1'b0, 3'b010, 32'd4, 32'd0, 1'b0, 32'h11111111);

        repeat (3) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
